// File: rtl/traffic_pkg.sv
// Shared phase encodings and lamp layout for the intersection controller,
// its light drivers and any status monitors.
package traffic_pkg;

  localparam int PHASE_W = 3;

  localparam logic [2:0] ST_MAIN_GREEN  = 3'd0;
  localparam logic [2:0] ST_MAIN_YELLOW = 3'd1;
  localparam logic [2:0] ST_ALLRED_A    = 3'd2;
  localparam logic [2:0] ST_SIDE_GREEN  = 3'd3;
  localparam logic [2:0] ST_SIDE_YELLOW = 3'd4;
  localparam logic [2:0] ST_ALLRED_B    = 3'd5;

  // Lamp vectors are ordered {r,y,g}, MSB first.
  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } lamp_t;

  localparam lamp_t LAMP_RED    = '{r: 1'b1, y: 1'b0, g: 1'b0};
  localparam lamp_t LAMP_YELLOW = '{r: 1'b0, y: 1'b1, g: 1'b0};
  localparam lamp_t LAMP_GREEN  = '{r: 1'b0, y: 1'b0, g: 1'b1};

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: clears on request, otherwise counts up and sticks
// at all-ones; done flags an exact match against a runtime limit.
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [TW-1:0] limit,
  output logic [TW-1:0] count,
  output logic          done
);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (count_q != {TW{1'b1}}) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == limit);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection sequencer: main road rests on green, side-road and
// pedestrian requests are latched and served through yellow and all-red.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int TW        = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               side_sensor,
  input  logic               ped_btn,
  output logic               main_r,
  output logic               main_y,
  output logic               main_g,
  output logic               side_r,
  output logic               side_y,
  output logic               side_g,
  output logic               ped_walk,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [TW-1:0] GMIN_LIM   = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_LIM   = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] YELLOW_LIM = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ALLRED_LIM = TW'(ALLRED_T - 1);

  logic [PHASE_W-1:0] state_q, state_d;
  logic               side_pend_q, side_pend_d;
  logic               ped_pend_q, ped_pend_d;
  logic               ped_srv_q, ped_srv_d;

  logic [TW-1:0] tmr_limit;
  logic [TW-1:0] tmr_count;
  logic          tmr_done;
  logic          tmr_clr;
  logic          green_min_met;
  logic          enter_side;
  logic          leave_allred_b;
  lamp_t         main_lamp, side_lamp;

  always_comb begin
    tmr_limit = GMIN_LIM;
    case (state_q)
      ST_MAIN_YELLOW, ST_SIDE_YELLOW: tmr_limit = YELLOW_LIM;
      ST_ALLRED_A, ST_ALLRED_B:       tmr_limit = ALLRED_LIM;
      ST_SIDE_GREEN:                  tmr_limit = GMAX_LIM;
      default:                        tmr_limit = GMIN_LIM;
    endcase
  end

  phase_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .limit (tmr_limit),
    .count (tmr_count),
    .done  (tmr_done)
  );

  assign green_min_met = (tmr_count >= GMIN_LIM);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MAIN_GREEN:
        if (green_min_met && (side_pend_q || ped_pend_q)) state_d = ST_MAIN_YELLOW;
      ST_MAIN_YELLOW:
        if (tmr_done) state_d = ST_ALLRED_A;
      ST_ALLRED_A:
        if (tmr_done) state_d = ST_SIDE_GREEN;
      // Side green ends on the cap, or early once the raw sensor goes quiet.
      ST_SIDE_GREEN:
        if (tmr_done || (green_min_met && !side_sensor)) state_d = ST_SIDE_YELLOW;
      ST_SIDE_YELLOW:
        if (tmr_done) state_d = ST_ALLRED_B;
      ST_ALLRED_B:
        if (tmr_done) state_d = ST_MAIN_GREEN;
      default:
        state_d = ST_MAIN_GREEN;
    endcase
  end

  assign tmr_clr        = (state_d != state_q);
  assign enter_side     = (state_q == ST_ALLRED_A) && (state_d == ST_SIDE_GREEN);
  assign leave_allred_b = (state_q == ST_ALLRED_B) && (state_d == ST_MAIN_GREEN);

  // Clearing on side-green entry wins over a request sampled on that same edge.
  always_comb begin
    side_pend_d = side_pend_q | (side_sensor && (state_q != ST_SIDE_GREEN));
    ped_pend_d  = ped_pend_q  | (ped_btn     && (state_q != ST_SIDE_GREEN));
    ped_srv_d   = ped_srv_q;
    if (enter_side) begin
      side_pend_d = 1'b0;
      ped_pend_d  = 1'b0;
      ped_srv_d   = ped_pend_q;
    end else if (leave_allred_b) begin
      ped_srv_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_MAIN_GREEN;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      ped_srv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      ped_srv_q   <= ped_srv_d;
    end
  end

  // Illegal encodings show red both ways until the next edge recovers them.
  always_comb begin
    main_lamp = LAMP_RED;
    side_lamp = LAMP_RED;
    case (state_q)
      ST_MAIN_GREEN:  main_lamp = LAMP_GREEN;
      ST_MAIN_YELLOW: main_lamp = LAMP_YELLOW;
      ST_SIDE_GREEN:  side_lamp = LAMP_GREEN;
      ST_SIDE_YELLOW: side_lamp = LAMP_YELLOW;
      default: begin
        main_lamp = LAMP_RED;
        side_lamp = LAMP_RED;
      end
    endcase
  end

  assign {main_r, main_y, main_g} = main_lamp;
  assign {side_r, side_y, side_g} = side_lamp;
  assign ped_walk = (state_q == ST_SIDE_GREEN) && ped_srv_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench for traffic_intersection_ctrl: each driven cycle pushes the
// expected phase/walk, which is popped and checked mid-cycle.
module tb_traffic_intersection_ctrl;
  import traffic_pkg::*;

  localparam logic [2:0] MG = 3'd0;
  localparam logic [2:0] MY = 3'd1;
  localparam logic [2:0] AA = 3'd2;
  localparam logic [2:0] SG = 3'd3;
  localparam logic [2:0] SY = 3'd4;
  localparam logic [2:0] AB = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       side_sensor = 1'b0;
  logic       ped_btn = 1'b0;
  logic       main_r, main_y, main_g;
  logic       side_r, side_y, side_g;
  logic       ped_walk;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct packed {
    logic [2:0] phase;
    logic       walk;
  } exp_t;

  exp_t sb_q[$];

  traffic_intersection_ctrl #(
    .TW(8), .GREEN_MIN(4), .GREEN_MAX(10), .YELLOW_T(2), .ALLRED_T(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .side_sensor (side_sensor),
    .ped_btn     (ped_btn),
    .main_r      (main_r),
    .main_y      (main_y),
    .main_g      (main_g),
    .side_r      (side_r),
    .side_y      (side_y),
    .side_g      (side_g),
    .ped_walk    (ped_walk),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected lamps {main_ryg, side_ryg} for each legal phase.
  function automatic logic [5:0] lamps_for(input logic [2:0] ph);
    case (ph)
      MG:      return 6'b001_100;
      MY:      return 6'b010_100;
      SG:      return 6'b100_001;
      SY:      return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic check_outputs(input string tag, input logic [2:0] ph, input logic walk);
    logic [5:0] lamps;
    lamps = {main_r, main_y, main_g, side_r, side_y, side_g};
    check_eq({tag, ".phase"}, 32'(phase), 32'(ph));
    check_eq({tag, ".lamps"}, 32'(lamps), 32'(lamps_for(ph)));
    check_eq({tag, ".walk"},  32'(ped_walk), 32'(walk));
    check_eq({tag, ".main1"}, 32'($countones({main_r, main_y, main_g})), 32'd1);
    check_eq({tag, ".side1"}, 32'($countones({side_r, side_y, side_g})), 32'd1);
  endtask

  // Called just after an edge (or reset release); drives the inputs sampled
  // on the coming edge, checks mid-cycle, then advances past that edge.
  task automatic run_cycle(input string scen, input logic sens, input logic btn,
                           input logic [2:0] ph, input logic walk);
    exp_t e;
    side_sensor = sens;
    ped_btn     = btn;
    sb_q.push_back('{phase: ph, walk: walk});
    @(negedge clk);
    e = sb_q.pop_front();
    check_outputs($sformatf("%s.c%0d", scen, cyc), e.phase, e.walk);
    $display("[TB] %s cycle %0d: sens=%0b btn=%0b phase=%0d walk=%0b", scen, cyc, sens, btn, phase, ped_walk);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_seg(input string scen, input logic sens, input logic btn,
                         input logic [2:0] ph, input logic walk, input int n);
    for (int i = 0; i < n; i++) run_cycle(scen, sens, btn, ph, walk);
  endtask

  task automatic do_reset(input string scen);
    rst_n       = 1'b0;
    side_sensor = 1'b0;
    ped_btn     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs({scen, ".in_reset"}, MG, 1'b0);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    // Reset idle: no requests, main green throughout.
    do_reset("idle");
    run_seg("idle", 1'b0, 1'b0, MG, 1'b0, 50);

    // Sensor held high: two full service rounds, then reset mid side-yellow.
    do_reset("held");
    for (int r = 0; r < 2; r++) begin
      run_seg("held", 1'b1, 1'b0, MG, 1'b0, 4);
      run_seg("held", 1'b1, 1'b0, MY, 1'b0, 2);
      run_seg("held", 1'b1, 1'b0, AA, 1'b0, 1);
      run_seg("held", 1'b1, 1'b0, SG, 1'b0, 10);
      if (r == 0) begin
        run_seg("held", 1'b1, 1'b0, SY, 1'b0, 2);
        run_seg("held", 1'b1, 1'b0, AB, 1'b0, 1);
      end
    end
    run_seg("held", 1'b1, 1'b0, SY, 1'b0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("held.async_rst", MG, 1'b0);
    $display("[TB] held async reset mid side-yellow: phase=%0d main_g=%0b side_r=%0b", phase, main_g, side_r);

    // Sensor dropped on side-green entry: exactly GREEN_MIN cycles of side green.
    do_reset("early");
    run_seg("early", 1'b1, 1'b0, MG, 1'b0, 4);
    run_seg("early", 1'b1, 1'b0, MY, 1'b0, 2);
    run_seg("early", 1'b1, 1'b0, AA, 1'b0, 1);
    run_seg("early", 1'b0, 1'b0, SG, 1'b0, 4);
    run_seg("early", 1'b0, 1'b0, SY, 1'b0, 2);
    run_seg("early", 1'b0, 1'b0, AB, 1'b0, 1);
    run_seg("early", 1'b0, 1'b0, MG, 1'b0, 10);

    // Pedestrian only: button sampled on edge 9, latched during cycle 10;
    // a second press inside side green (cycle 15) must be ignored.
    do_reset("ped");
    run_seg("ped", 1'b0, 1'b0, MG, 1'b0, 9);
    run_seg("ped", 1'b0, 1'b1, MG, 1'b0, 1);
    run_seg("ped", 1'b0, 1'b0, MG, 1'b0, 1);
    run_seg("ped", 1'b0, 1'b0, MY, 1'b0, 2);
    run_seg("ped", 1'b0, 1'b0, AA, 1'b0, 1);
    run_seg("ped", 1'b0, 1'b0, SG, 1'b1, 1);
    run_seg("ped", 1'b0, 1'b1, SG, 1'b1, 1);
    run_seg("ped", 1'b0, 1'b0, SG, 1'b1, 2);
    run_seg("ped", 1'b0, 1'b0, SY, 1'b0, 2);
    run_seg("ped", 1'b0, 1'b0, AB, 1'b0, 1);
    run_seg("ped", 1'b0, 1'b0, MG, 1'b0, 30);

    // Illegal state 6 recovers to main green on the next edge.
    do_reset("illegal");
    run_seg("illegal", 1'b0, 1'b0, MG, 1'b0, 3);
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    @(negedge clk);
    check_eq("illegal.phase6", 32'(phase), 32'd6);
    check_eq("illegal.main_le1", 32'($countones({main_r, main_y, main_g}) <= 1), 32'd1);
    check_eq("illegal.side_le1", 32'($countones({side_r, side_y, side_g}) <= 1), 32'd1);
    $display("[TB] illegal forced: phase=%0d", phase);
    @(posedge clk);
    #1;
    run_seg("illegal", 1'b0, 1'b0, MG, 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
